// File: rtl/obstacle_scroller.sv
// Scrolls two mountain gaps and a lava block toward the plane, picks gap heights from an LFSR, keeps a pass score.
// Latency: outputs are registered, and position changes appear one clk after frame_tick.
// Backpressure: none. frame_tick is consumed when it arrives, and game_over freezes the scene.
module obstacle_scroller #(
    parameter int SCREEN_W    = 320,
    parameter int SPACING     = 160,
    parameter int LAVA_OFFSET = 80,
    parameter int Y_MIN       = 60,
    parameter int LAVA_DROP   = 2,
    parameter int LAVA_FLOOR  = 232
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_over,
    output logic [9:0] mountain1_x,
    output logic [9:0] mountain1_y,
    output logic [9:0] mountain2_x,
    output logic [9:0] mountain2_y,
    output logic [9:0] lava_x,
    output logic [9:0] lava_y,
    output logic [7:0] score,
    output logic       running
);

    localparam logic [9:0] X_WRAP       = 10'(SCREEN_W - 1);
    localparam logic [9:0] M2_START     = 10'(SCREEN_W - 1 + SPACING);
    localparam logic [9:0] LAVA_START   = 10'(SCREEN_W - 1 + LAVA_OFFSET);
    localparam logic [9:0] GAP_RESET    = 10'd120;
    localparam logic [9:0] LAVA_Y_RESET = 10'd8;
    localparam logic [9:0] Y_BASE       = 10'(Y_MIN);
    localparam logic [9:0] DROP         = 10'(LAVA_DROP);
    localparam logic [9:0] FLOOR        = 10'(LAVA_FLOOR);
    localparam logic [7:0] LFSR_SEED    = 8'hA5;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t     state;
    logic [7:0] lfsr;

    logic       lfsr_fb;
    logic [6:0] gap_v;
    logic [6:0] gap_off;
    logic [9:0] gap_y;
    logic [1:0] spd_sh;
    logic [9:0] spd;
    logic       m1_wrap, m2_wrap, lava_wrap;
    logic [1:0] wrap_cnt;
    logic [8:0] score_sum;
    logic [7:0] score_nxt;
    logic [9:0] lava_y_inc;
    logic [9:0] lava_y_nxt;

    always_comb begin
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        gap_v     = lfsr[6:0];
        // Fold the top of the 7-bit range down so the gap centre stays within 60..180.
        gap_off   = (gap_v > 7'd120) ? (gap_v - 7'd64) : gap_v;
        gap_y     = Y_BASE + {3'b000, gap_off};

        spd_sh    = (score >= 8'd24) ? 2'd3 : score[4:3];
        spd       = 10'd1 + {8'd0, spd_sh};

        m1_wrap   = mountain1_x < spd;
        m2_wrap   = mountain2_x < spd;
        lava_wrap = lava_x < spd;

        wrap_cnt  = {1'b0, m1_wrap} + {1'b0, m2_wrap} + {1'b0, lava_wrap};
        score_sum = {1'b0, score} + {7'd0, wrap_cnt};
        score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];

        lava_y_inc = lava_y + DROP;
        if (lava_wrap)
            lava_y_nxt = LAVA_Y_RESET;
        else if (lava_y_inc > FLOOR)
            lava_y_nxt = FLOOR;
        else
            lava_y_nxt = lava_y_inc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            mountain1_x <= X_WRAP;
            mountain2_x <= M2_START;
            lava_x      <= LAVA_START;
            mountain1_y <= GAP_RESET;
            mountain2_y <= GAP_RESET;
            lava_y      <= LAVA_Y_RESET;
            score       <= 8'd0;
            running     <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A crash on a frame_tick cycle wins: the scene freezes where the checker saw it.
                    if (game_over) begin
                        state   <= OVER;
                        running <= 1'b0;
                    end else if (frame_tick) begin
                        mountain1_x <= m1_wrap ? X_WRAP : (mountain1_x - spd);
                        mountain2_x <= m2_wrap ? X_WRAP : (mountain2_x - spd);
                        lava_x      <= lava_wrap ? X_WRAP : (lava_x - spd);
                        if (m1_wrap)
                            mountain1_y <= gap_y;
                        if (m2_wrap)
                            mountain2_y <= gap_y;
                        lava_y <= lava_y_nxt;
                        score  <= score_nxt;
                    end
                end
                OVER: begin
                    if (start) begin
                        state       <= RUN;
                        running     <= 1'b1;
                        mountain1_x <= X_WRAP;
                        mountain2_x <= M2_START;
                        lava_x      <= LAVA_START;
                        mountain1_y <= GAP_RESET;
                        mountain2_y <= GAP_RESET;
                        lava_y      <= LAVA_Y_RESET;
                        score       <= 8'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
